// File: rtl/norm_shift_left_seq.sv
// Iterative 24-bit left-shift normalizer, one binary stage (16/8/4/2/1) per cycle.
// Build option: NORM_DENORM_CLAMP_EN limits shifting so the exponent stays >= 1.
module norm_shift_left_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_mant,
   input  logic [7:0]  in_exp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] out_mant,
   output logic [7:0]  out_exp,
   output logic [4:0]  out_nshift,
   output logic        out_zero,
   output logic        out_uflow
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S16  = 3'd1,
      S8   = 3'd2,
      S4   = 3'd3,
      S2   = 3'd4,
      S1   = 3'd5,
      DONE = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] mant_q, mant_d;
   logic [7:0]  exp_q, exp_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        zero_q, zero_d;

   logic        accept;
   logic        hit;
   logic [4:0]  k;
   logic [8:0]  d;

`ifdef NORM_DENORM_CLAMP_EN
   logic [8:0]  lim;
   logic [8:0]  sum;
`endif

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mant_q  <= '0;
         exp_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = S16;
         S16:     state_d = S8;
         S8:      state_d = S4;
         S4:      state_d = S2;
         S2:      state_d = S1;
         S1:      state_d = DONE;
         DONE: begin
            if (out_ready) state_d = in_valid ? S16 : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage decision: shift by k only when the top k bits are all zero
   always_comb begin
      k   = 5'd0;
      hit = 1'b0;
      unique case (state_q)
         S16: begin k = 5'd16; hit = (mant_q[23:8]  == 16'd0); end
         S8:  begin k = 5'd8;  hit = (mant_q[23:16] == 8'd0);  end
         S4:  begin k = 5'd4;  hit = (mant_q[23:20] == 4'd0);  end
         S2:  begin k = 5'd2;  hit = (mant_q[23:22] == 2'd0);  end
         S1:  begin k = 5'd1;  hit = ~mant_q[23];              end
         default: begin k = 5'd0; hit = 1'b0; end
      endcase
`ifdef NORM_DENORM_CLAMP_EN
      lim = (exp_q == 8'd0) ? 9'd0 : ({1'b0, exp_q} - 9'd1);
      sum = {4'd0, cnt_q} + {4'd0, k};
      if (sum > lim) hit = 1'b0;
`endif
   end

   always_comb begin
      mant_d = mant_q;
      exp_d  = exp_q;
      cnt_d  = cnt_q;
      zero_d = zero_q;
      if (accept) begin
         mant_d = in_mant;
         exp_d  = in_exp;
         cnt_d  = 5'd0;
         zero_d = (in_mant == 24'd0);
      end else if (hit) begin
         mant_d = mant_q << k;
         cnt_d  = cnt_q + k;
      end
   end

   assign d = {1'b0, exp_q} - {4'd0, cnt_q};

   always_comb begin
      in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
      out_valid  = 1'b0;
      out_mant   = '0;
      out_exp    = '0;
      out_nshift = '0;
      out_zero   = 1'b0;
      out_uflow  = 1'b0;
      if (state_q == DONE) begin
         out_valid = 1'b1;
         if (zero_q) begin
            out_zero = 1'b1;
         end else begin
            out_mant   = mant_q;
            out_nshift = cnt_q;
`ifdef NORM_DENORM_CLAMP_EN
            out_exp    = mant_q[23] ? d[7:0] : 8'd0;
`else
            // d is signed 9-bit; zero or negative means underflow
            if (d[8] || (d == 9'd0)) begin
               out_uflow = 1'b1;
            end else begin
               out_exp = d[7:0];
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_norm_shift_left_seq.sv
// Directed self-checking bench for norm_shift_left_seq.
// Expectations follow NORM_DENORM_CLAMP_EN when it is defined.
module tb_norm_shift_left_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_mant;
   logic [7:0]  in_exp;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_mant;
   logic [7:0]  out_exp;
   logic [4:0]  out_nshift;
   logic        out_zero;
   logic        out_uflow;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   norm_shift_left_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mant    (in_mant),
      .in_exp     (in_exp),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mant   (out_mant),
      .out_exp    (out_exp),
      .out_nshift (out_nshift),
      .out_zero   (out_zero),
      .out_uflow  (out_uflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept an operand, then run the five stages checking fixed latency
   task automatic run(input logic [23:0] m, input logic [7:0] e,
                      input string tag);
      in_valid = 1'b1;
      in_mant  = m;
      in_exp   = e;
      step();
      in_valid = 1'b0;
      in_mant  = 24'hABCDEF;
      in_exp   = 8'hEE;
      chk({tag, ".busy_rdy"}, {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 4; i++) step();
      chk({tag, ".lat4"}, {31'd0, out_valid}, 32'd0);
      step();
      chk({tag, ".lat5"}, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic res(input string tag, input logic [23:0] m,
                      input logic [7:0] e, input logic [4:0] n,
                      input logic z, input logic u);
      chk({tag, ".mant"}, {8'd0, out_mant}, {8'd0, m});
      chk({tag, ".exp"}, {24'd0, out_exp}, {24'd0, e});
      chk({tag, ".nshift"}, {27'd0, out_nshift}, {27'd0, n});
      chk({tag, ".zero"}, {31'd0, out_zero}, {31'd0, z});
      chk({tag, ".uflow"}, {31'd0, out_uflow}, {31'd0, u});
   endtask

   task automatic retire(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, ".ret_vld"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ".ret_rdy"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_mant   = '0;
      in_exp    = '0;
      out_ready = 1'b0;
      #12;
      chk("rst.rdy", {31'd0, in_ready}, 32'd1);
      chk("rst.vld", {31'd0, out_valid}, 32'd0);
      res("rst", 24'd0, 8'd0, 5'd0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      run(24'h000001, 8'd100, "t1");
      res("t1", 24'h800000, 8'd77, 5'd23, 1'b0, 1'b0);
      retire("t1");

      run(24'h800000, 8'd5, "t2");
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2.hold_vld", {31'd0, out_valid}, 32'd1);
         chk("t2.hold_mant", {8'd0, out_mant}, 32'h800000);
      end
      res("t2", 24'h800000, 8'd5, 5'd0, 1'b0, 1'b0);
      retire("t2");

      run(24'd0, 8'd50, "t3");
      res("t3", 24'd0, 8'd0, 5'd0, 1'b1, 1'b0);
      retire("t3");

      run(24'h000100, 8'd10, "t4");
`ifdef NORM_DENORM_CLAMP_EN
      res("t4", 24'h020000, 8'd0, 5'd9, 1'b0, 1'b0);
`else
      res("t4", 24'h800000, 8'd0, 5'd15, 1'b0, 1'b1);
`endif
      retire("t4");

      run(24'h400000, 8'd1, "t5");
`ifdef NORM_DENORM_CLAMP_EN
      res("t5", 24'h400000, 8'd0, 5'd0, 1'b0, 1'b0);
`else
      res("t5", 24'h800000, 8'd0, 5'd1, 1'b0, 1'b1);
`endif
      retire("t5");

      // Same-edge retire and accept
      run(24'h0000FF, 8'd20, "t6a");
      res("t6a", 24'hFF0000, 8'd4, 5'd16, 1'b0, 1'b0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mant   = 24'h00F000;
      in_exp    = 8'd40;
      #1;
      chk("t6.rdy_done", {31'd0, in_ready}, 32'd1);
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("t6.vld_drop", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 4; i++) step();
      chk("t6.lat4", {31'd0, out_valid}, 32'd0);
      step();
      chk("t6.lat5", {31'd0, out_valid}, 32'd1);
      res("t6b", 24'hF00000, 8'd32, 5'd8, 1'b0, 1'b0);
      retire("t6b");

      // Reset pulse while in S4
      in_valid = 1'b1;
      in_mant  = 24'h000003;
      in_exp   = 8'd90;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("t7.pre_rdy", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("t7.rst_rdy", {31'd0, in_ready}, 32'd1);
      chk("t7.rst_vld", {31'd0, out_valid}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("t7.idle_vld", {31'd0, out_valid}, 32'd0);
      run(24'h400000, 8'd3, "t8");
      res("t8", 24'h800000, 8'd2, 5'd1, 1'b0, 1'b0);
      retire("t8");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, required finish");
      $fatal(1);
   end

endmodule
